fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_stage_if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: NOP encoding, FSM encodings, PC step.
// IF/ID update operations are an enum; FSM states stay legacy-width constants.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_BUBBLE,
    IFID_LOAD
  } ifid_op_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch stage and memory.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (output imem_req_o, output imem_addr_o,
                  input  imem_ready_i, input imem_rdata_i);
  modport slave  (input  imem_req_o, input imem_addr_o,
                  output imem_ready_i, output imem_rdata_i);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold, insert a NOP bubble, or load a fetched word.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  ifid_op_e    op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] PC_o,
  output logic [31:0] Instr_o,
  output logic        Valid_o
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // A bubble keeps the old PC so downstream debug still sees where we were.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      case (op_i)
        IFID_LOAD: begin
          pc_q    <= pc_i;
          instr_q <= instr_i;
          valid_q <= 1'b1;
        end
        IFID_BUBBLE: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign PC_o    = pc_q;
  assign Instr_o = instr_q;
  assign Valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single outstanding request, stall buffer, branch redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          Stall_i,
  input  logic          Branch_i,
  input  logic [31:0]   BranchTarget_i,
  fetch_stage_if.master imem,
  output logic [31:0]   PC_o,
  output logic [31:0]   Instr_o,
  output logic          Valid_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  ifid_op_e    ifid_op;
  logic [31:0] ifid_instr;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    ifid_op    = IFID_HOLD;
    ifid_instr = imem.imem_rdata_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Branch wins over stall and any response arriving this cycle.
        if (Branch_i) begin
          pc_d    = word_align(BranchTarget_i);
          ifid_op = IFID_BUBBLE;
        end else if (imem.imem_ready_i) begin
          if (Stall_i) begin
            buf_d   = imem.imem_rdata_i;
            state_d = ST_HOLD;
          end else begin
            ifid_op = IFID_LOAD;
            pc_d    = pc_q + PC_INCR;
          end
        end else if (!Stall_i) begin
          ifid_op = IFID_BUBBLE;
        end
      end
      ST_HOLD: begin
        if (Branch_i) begin
          pc_d    = word_align(BranchTarget_i);
          ifid_op = IFID_BUBBLE;
          state_d = ST_FETCH;
        end else if (!Stall_i) begin
          ifid_op    = IFID_LOAD;
          ifid_instr = buf_q;
          pc_d       = pc_q + PC_INCR;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  assign imem.imem_req_o  = (state_q == ST_FETCH);
  assign imem.imem_addr_o = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .op_i    (ifid_op),
    .pc_i    (pc_q),
    .instr_i (ifid_instr),
    .PC_o    (PC_o),
    .Instr_o (Instr_o),
    .Valid_o (Valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a behavioural fetch model;
// a second instance starts at the top of the address space to exercise wrap.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        start, stall, branch;
  logic [31:0] target;
  logic        ready;
  logic [31:0] rdata;

  logic [31:0] pc_o   [2];
  logic [31:0] instr_o[2];
  logic        valid_o[2];

  fetch_stage_if if0 ();
  fetch_stage_if if1 ();

  assign if0.imem_ready_i = ready;
  assign if0.imem_rdata_i = rdata;
  assign if1.imem_ready_i = ready;
  assign if1.imem_rdata_i = rdata;

  fetch_stage dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .Stall_i(stall),
    .Branch_i(branch), .BranchTarget_i(target), .imem(if0.master),
    .PC_o(pc_o[0]), .Instr_o(instr_o[0]), .Valid_o(valid_o[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .Stall_i(stall),
    .Branch_i(branch), .BranchTarget_i(target), .imem(if1.master),
    .PC_o(pc_o[1]), .Instr_o(instr_o[1]), .Valid_o(valid_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: running/holding flags, fetch pointer, one-word buffer.
  logic [31:0] rst_pc [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  bit          m_run  [2];
  bit          m_hold [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_buf  [2];
  logic [31:0] m_opc  [2];
  logic [31:0] m_oin  [2];
  bit          m_ov   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_hold[i] = 0; m_pc[i] = rst_pc[i]; m_buf[i] = '0;
      m_opc[i] = '0; m_oin[i] = NOP; m_ov[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!m_run[i]) begin
        if (start) m_run[i] = 1;
      end else if (branch) begin
        m_pc[i] = {target[31:2], 2'b00};
        m_ov[i] = 0; m_oin[i] = NOP; m_hold[i] = 0;
      end else if (m_hold[i]) begin
        if (!stall) begin
          m_opc[i] = m_pc[i]; m_oin[i] = m_buf[i]; m_ov[i] = 1;
          m_pc[i] = m_pc[i] + 32'd4; m_hold[i] = 0;
        end
      end else if (ready) begin
        if (stall) begin
          m_buf[i] = rdata; m_hold[i] = 1;
        end else begin
          m_opc[i] = m_pc[i]; m_oin[i] = rdata; m_ov[i] = 1;
          m_pc[i] = m_pc[i] + 32'd4;
        end
      end else if (!stall) begin
        m_ov[i] = 0; m_oin[i] = NOP;
      end
    end
  endtask

  task automatic check_all();
    check("req0",   {31'd0, if0.imem_req_o}, {31'd0, m_run[0] && !m_hold[0]});
    check("addr0",  if0.imem_addr_o, m_pc[0]);
    check("pc0",    pc_o[0], m_opc[0]);
    check("instr0", instr_o[0], m_oin[0]);
    check("valid0", {31'd0, valid_o[0]}, {31'd0, m_ov[0]});
    check("req1",   {31'd0, if1.imem_req_o}, {31'd0, m_run[1] && !m_hold[1]});
    check("addr1",  if1.imem_addr_o, m_pc[1]);
    check("pc1",    pc_o[1], m_opc[1]);
    check("instr1", instr_o[1], m_oin[1]);
    check("valid1", {31'd0, valid_o[1]}, {31'd0, m_ov[1]});
  endtask

  // Called at a negedge: drive inputs, advance model, check at next negedge.
  task automatic step(input logic st, input logic sl, input logic br,
                      input logic [31:0] tg, input logic rdy, input logic [31:0] rd);
    start = st; stall = sl; branch = br; target = tg; ready = rdy; rdata = rd;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; branch = 0; target = '0; ready = 0; rdata = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Idle ignores ready and branch until start.
    step(0, 0, 1, 32'h40, 1, 32'hDEAD_BEEF);
    step(1, 0, 0, '0, 0, '0);
    // Back-to-back fetches, rdata mirrors address.
    for (int k = 0; k < 4; k++) step(0, 0, 0, '0, 1, m_pc[0]);
    check("seq_pc", pc_o[0], 32'h0000_000C);
    check("wrap_addr", if1.imem_addr_o, 32'h0000_000C);

    // Stall while response arrives, hold three cycles, then release.
    step(0, 1, 0, '0, 1, 32'hA5A5_0001);
    step(0, 1, 0, '0, 1, 32'h1111_1111);
    step(0, 1, 0, '0, 0, 32'h2222_2222);
    check("hold_req", {31'd0, if0.imem_req_o}, 32'd0);
    step(0, 0, 0, '0, 0, '0);
    check("hold_out", instr_o[0], 32'hA5A5_0001);

    // Branch beats simultaneous stall and ready.
    step(0, 1, 1, 32'h0000_0103, 1, 32'h3333_3333);
    check("br_instr", instr_o[0], NOP);
    check("br_addr", if0.imem_addr_o, 32'h0000_0100);

    // Two cycles without response and no stall: two bubbles.
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    check("bub_addr", if0.imem_addr_o, 32'h0000_0100);

    // Random traffic.
    for (int k = 0; k < 2000; k++)
      step(($urandom % 2) == 0, ($urandom % 10) < 3, ($urandom % 12) == 0,
           $urandom, ($urandom % 10) < 6, $urandom);

    // Asynchronous reset between edges during FETCH.
    step(0, 0, 0, '0, 1, 32'h7777_7777);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
    step(0, 0, 0, '0, 1, 32'h8888_8888);
    step(0, 0, 0, '0, 1, 32'h9999_9999);
    step(1, 0, 0, '0, 1, 32'h9999_9999);
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 1, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
